// File: rtl/tree_node_loader_if.sv
`timescale 1ns/1ps
// Bundle of the loader's command, node-data, BRAM-port and status signals.
// The slave side is the loader; the master side is the host plus level BRAMs.
interface tree_node_loader_if #(
    parameter int NODE_WIDTH = 40,
    parameter int NODE_ADDR  = 9,
    parameter int LEVELS     = 4,
    parameter int LEVEL_SEL  = 2
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [LEVEL_SEL-1:0]         cmd_level;
    logic [NODE_ADDR-1:0]         cmd_base;
    logic [NODE_ADDR:0]           cmd_count;
    logic [NODE_WIDTH-1:0]        data_in;
    logic                         data_valid;
    logic                         data_ready;
    logic [LEVELS-1:0]            wr_we;
    logic [NODE_ADDR-1:0]         wr_addr;
    logic [NODE_WIDTH-1:0]        wr_din;
    logic [LEVELS*NODE_WIDTH-1:0] rd_dout;
    logic                         busy;
    logic                         done;
    logic                         err;

    modport master (
        output cmd_valid, cmd_level, cmd_base, cmd_count, data_in, data_valid, rd_dout,
        input  cmd_ready, data_ready, wr_we, wr_addr, wr_din, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_level, cmd_base, cmd_count, data_in, data_valid, rd_dout,
        output cmd_ready, data_ready, wr_we, wr_addr, wr_din, busy, done, err
    );
endinterface

// File: rtl/tree_node_loader.sv
`timescale 1ns/1ps
// Loads a run of node words into one level BRAM, reads the run back through
// the shared port and compares XOR checksums of what was written and read.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// WRITE    | accepting node words, one BRAM write per accepted word
// VERIFY   | issuing one read per cycle over the written range
// DRAIN    | waiting for outstanding reads to return
// DONE     | one-cycle done pulse, err reports range or checksum failure
module tree_node_loader #(
    parameter int NODE_WIDTH = 40,
    parameter int NODE_ADDR  = 9,
    parameter int LEVELS     = 4,
    parameter int LEVEL_SEL  = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                RST,
    tree_node_loader_if.slave   bus
);
    localparam int DEPTH = 1 << NODE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [LEVEL_SEL-1:0]    r_level;
    logic [NODE_ADDR-1:0]    r_base;
    logic [NODE_ADDR:0]      r_count;
    logic [NODE_ADDR:0]      r_wr_idx;
    logic [NODE_ADDR:0]      r_rd_idx;
    logic [NODE_WIDTH-1:0]   r_wr_sum;
    logic [NODE_WIDTH-1:0]   r_rd_sum;
    logic                    r_range_err;
    logic [RD_LATENCY-1:0]   r_tag;
    logic                    r_rd_vld;
    logic [LEVELS-1:0]       r_wr_we;
    logic [NODE_ADDR-1:0]    r_wr_addr;
    logic [NODE_WIDTH-1:0]   r_wr_din;

    logic [NODE_ADDR+1:0]    w_end;
    logic                    w_range_bad;
    logic [NODE_ADDR:0]      w_last;
    logic [LEVELS-1:0]       w_level_oh;
    logic [NODE_WIDTH-1:0]   w_rd_word;

    // The end address is formed one bit wider than the count so an oversized
    // count cannot wrap around and slip past the range check.
    assign w_end       = {2'b00, bus.cmd_base} + {1'b0, bus.cmd_count};
    assign w_range_bad = (bus.cmd_count == '0) || (w_end > (NODE_ADDR+2)'(DEPTH));
    assign w_last      = r_count - (NODE_ADDR+1)'(1);
    assign w_level_oh  = LEVELS'(1) << r_level;

    // Pick the read-data slice of the level being loaded.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (r_level == LEVEL_SEL'(i)) begin
                w_rd_word = bus.rd_dout[i*NODE_WIDTH +: NODE_WIDTH];
            end
        end
    end

    // Load sequencer: state, registered BRAM port, read tags and checksums.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_wr_sum    <= '0;
            r_rd_sum    <= '0;
            r_range_err <= 1'b0;
            r_tag       <= '0;
            r_rd_vld    <= 1'b0;
            r_wr_we     <= '0;
            r_wr_addr   <= '0;
            r_wr_din    <= '0;
        end else begin
            r_wr_we  <= '0;
            r_tag    <= r_tag << 1;
            r_rd_vld <= r_tag[RD_LATENCY-1];
            if (r_rd_vld) begin
                r_rd_sum <= r_rd_sum ^ w_rd_word;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_level     <= bus.cmd_level;
                        r_base      <= bus.cmd_base;
                        r_count     <= bus.cmd_count;
                        r_wr_idx    <= '0;
                        r_rd_idx    <= '0;
                        r_wr_sum    <= '0;
                        r_rd_sum    <= '0;
                        r_range_err <= w_range_bad;
                        r_state     <= w_range_bad ? S_DONE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.data_valid) begin
                        r_wr_we   <= w_level_oh;
                        r_wr_addr <= r_base + r_wr_idx[NODE_ADDR-1:0];
                        r_wr_din  <= bus.data_in;
                        r_wr_sum  <= r_wr_sum ^ bus.data_in;
                        r_wr_idx  <= r_wr_idx + (NODE_ADDR+1)'(1);
                        if (r_wr_idx == w_last) begin
                            r_state <= S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    r_wr_addr <= r_base + r_rd_idx[NODE_ADDR-1:0];
                    r_tag[0]  <= 1'b1;
                    r_rd_idx  <= r_rd_idx + (NODE_ADDR+1)'(1);
                    if (r_rd_idx == w_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The read leaving the tag chain now is folded in this
                    // same cycle, so the sum is complete in DONE.
                    if (r_tag == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.data_ready = (r_state == S_WRITE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = (r_state == S_DONE) && (r_range_err || (r_wr_sum != r_rd_sum));
    assign bus.wr_we      = r_wr_we;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_din     = r_wr_din;
endmodule

// File: tb/tb_tree_node_loader.sv
`timescale 1ns/1ps
// Directed bench for tree_node_loader with a 2-cycle-latency BRAM model.
module tb_tree_node_loader;
    localparam int NW   = 40;
    localparam int NA   = 9;
    localparam int LV   = 4;
    localparam int LS   = 2;
    localparam int SNAP = 8192;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    tree_node_loader_if #(.NODE_WIDTH(NW), .NODE_ADDR(NA), .LEVELS(LV), .LEVEL_SEL(LS)) bus();

    tree_node_loader #(
        .NODE_WIDTH(NW), .NODE_ADDR(NA), .LEVELS(LV), .LEVEL_SEL(LS), .RD_LATENCY(2)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle index; cycle k is the interval after the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Level BRAMs: write port plus 2-stage read pipeline, optional bit-0 corruption.
    logic [NW-1:0] mem [LV][512];
    logic [NW-1:0] rd1 [LV];
    logic [NW-1:0] rd2 [LV];
    logic          corrupt_en = 1'b0;
    int            corrupt_lvl = 0;
    logic [NA-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        for (int l = 0; l < LV; l++) begin
            if (bus.wr_we[l]) mem[l][bus.wr_addr] <= bus.wr_din;
            rd1[l] <= mem[l][bus.wr_addr] ^
                      {{(NW-1){1'b0}}, (corrupt_en && l == corrupt_lvl && bus.wr_addr == corrupt_addr)};
            rd2[l] <= rd1[l];
        end
    end

    always_comb begin
        bus.rd_dout = '0;
        for (int l = 0; l < LV; l++) bus.rd_dout[l*NW +: NW] = rd2[l];
    end

    // Per-cycle snapshots and a log of every write.
    logic [3:0]    s_we   [SNAP];
    logic [NA-1:0] s_addr [SNAP];
    logic          s_busy [SNAP];
    logic          s_done [SNAP];
    logic          s_err  [SNAP];
    logic          s_cr   [SNAP];
    logic          s_dr   [SNAP];
    int            wq_cyc [$];
    logic [3:0]    wq_we  [$];
    logic [NA-1:0] wq_addr[$];
    logic [NW-1:0] wq_din [$];
    int            hs     [1024];

    always @(negedge clk) begin
        if (cyc < SNAP) begin
            s_we[cyc]   = bus.wr_we;
            s_addr[cyc] = bus.wr_addr;
            s_busy[cyc] = bus.busy;
            s_done[cyc] = bus.done;
            s_err[cyc]  = bus.err;
            s_cr[cyc]   = bus.cmd_ready;
            s_dr[cyc]   = bus.data_ready;
        end
        if (bus.wr_we != '0) begin
            wq_cyc.push_back(cyc);
            wq_we.push_back(bus.wr_we);
            wq_addr.push_back(bus.wr_addr);
            wq_din.push_back(bus.wr_din);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_sig(input int which, input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) begin
            if (k >= 0 && k < SNAP) begin
                case (which)
                    0:       if (s_busy[k] === 1'b1) n++;
                    1:       if (s_done[k] === 1'b1) n++;
                    2:       if (s_err[k]  === 1'b1) n++;
                    default: if (s_cr[k]   === 1'b1) n++;
                endcase
            end
        end
        return n;
    endfunction

    function automatic logic [NW-1:0] word_of(input logic [NW-1:0] seed, input logic [NW-1:0] step, input int i);
        return seed + NW'(i) * step;
    endfunction

    task automatic clear_log();
        wq_cyc.delete(); wq_we.delete(); wq_addr.delete(); wq_din.delete();
    endtask

    task automatic send_cmd(input logic [LS-1:0] lvl, input logic [NA-1:0] base, input logic [NA:0] cnt,
                            input bit hold, output int t0);
        bus.cmd_level = lvl;
        bus.cmd_base  = base;
        bus.cmd_count = cnt;
        bus.cmd_valid = 1'b1;
        t0 = -1;
        for (int i = 0; i < 4000 && t0 < 0; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) t0 = cyc;
        end
        check("cmd_accepted", 64'(t0 >= 0), 64'd1);
        @(posedge clk); #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps, input logic [NW-1:0] seed, input logic [NW-1:0] step);
        int  idx = 0;
        bit  phase = 1'b0;
        for (int b = 0; b < 4000 && idx < n; b++) begin
            bus.data_valid = gaps ? phase : 1'b1;
            bus.data_in    = word_of(seed, step, idx);
            @(negedge clk);
            if (bus.data_valid && bus.data_ready) begin
                hs[idx] = cyc;
                idx++;
            end
            @(posedge clk); #1;
            phase = ~phase;
        end
        bus.data_valid = 1'b0;
        check("words_accepted", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input int budget, output int td, output logic e);
        td = -1;
        e  = 1'b0;
        for (int i = 0; i < budget && td < 0; i++) begin
            @(negedge clk);
            if (bus.done) begin
                td = cyc;
                e  = bus.err;
            end
        end
        check("done_seen", 64'(td >= 0), 64'd1);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"},  64'(bus.cmd_ready),  64'd1);
        check({tag, "_data_ready"}, 64'(bus.data_ready), 64'd0);
        check({tag, "_wr_we"},      64'(bus.wr_we),      64'd0);
        check({tag, "_wr_addr"},    64'(bus.wr_addr),    64'd0);
        check({tag, "_wr_din"},     64'(bus.wr_din),     64'd0);
        check({tag, "_busy"},       64'(bus.busy),       64'd0);
        check({tag, "_done"},       64'(bus.done),       64'd0);
        check({tag, "_err"},        64'(bus.err),        64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   t0, t1, td, ta;
    logic e;
    logic [NW-1:0] seed, step;

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_level  = '0;
        bus.cmd_base   = '0;
        bus.cmd_count  = '0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        RST = 1'b0;

        // Level 2, base 0x010, four words 1..4 with no gaps
        clear_log();
        send_cmd(2'd2, 9'h010, 10'd4, 1'b0, t0);
        send_words(4, 1'b0, 40'd1, 40'd1);
        wait_done(100, td, e);
        settle();
        check("t1_done_cycle", 64'(td - t0), 64'd12);
        check("t1_err", 64'(e), 64'd0);
        check("t1_nwrites", 64'(wq_cyc.size()), 64'd4);
        for (int i = 0; i < 4 && i < wq_cyc.size(); i++) begin
            check($sformatf("t1_we%0d", i),   64'(wq_we[i]),   64'h4);
            check($sformatf("t1_addr%0d", i), 64'(wq_addr[i]), 64'(9'h010 + 9'(i)));
            check($sformatf("t1_din%0d", i),  64'(wq_din[i]),  64'(i + 1));
            check($sformatf("t1_wcyc%0d", i), 64'(wq_cyc[i]),  64'(t0 + 2 + i));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rd_addr%0d", i), 64'(s_addr[t0 + 6 + i]), 64'(9'h010 + 9'(i)));
            check($sformatf("t1_rd_we%0d", i),   64'(s_we[t0 + 6 + i]),   64'd0);
        end
        check("t1_busy_cycles", 64'(count_sig(0, t0, t0 + 14)), 64'd12);
        check("t1_busy_at_accept", 64'(s_busy[t0]), 64'd0);
        check("t1_mem_013", 64'(mem[2][9'h013]), 64'd4);

        // Base 0x1FF, count 1: fits exactly
        clear_log();
        send_cmd(2'd0, 9'h1FF, 10'd1, 1'b0, t0);
        send_words(1, 1'b0, 40'hAB_CDEF_0123, 40'd1);
        wait_done(100, td, e);
        settle();
        check("t2_done_cycle", 64'(td - t0), 64'd6);
        check("t2_err", 64'(e), 64'd0);
        check("t2_nwrites", 64'(wq_cyc.size()), 64'd1);
        if (wq_cyc.size() > 0) check("t2_addr", 64'(wq_addr[0]), 64'h1FF);
        check("t2_mem", 64'(mem[0][9'h1FF]), 64'hAB_CDEF_0123);

        // Base 0x1FF, count 2: out of range
        clear_log();
        send_cmd(2'd1, 9'h1FF, 10'd2, 1'b0, t0);
        wait_done(10, td, e);
        settle();
        check("t3_done_cycle", 64'(td - t0), 64'd1);
        check("t3_err", 64'(e), 64'd1);
        check("t3_nwrites", 64'(wq_cyc.size()), 64'd0);
        check("t3_busy_cycles", 64'(count_sig(0, t0, t0 + 3)), 64'd1);

        // Count 0
        clear_log();
        send_cmd(2'd3, 9'h005, 10'd0, 1'b0, t0);
        wait_done(10, td, e);
        settle();
        check("t4_done_cycle", 64'(td - t0), 64'd1);
        check("t4_err", 64'(e), 64'd1);
        check("t4_nwrites", 64'(wq_cyc.size()), 64'd0);

        // Corrupted readback at base+1
        clear_log();
        corrupt_en   = 1'b1;
        corrupt_lvl  = 1;
        corrupt_addr = 9'h041;
        send_cmd(2'd1, 9'h040, 10'd4, 1'b0, t0);
        send_words(4, 1'b0, 40'h55_0000_0000, 40'd3);
        wait_done(100, td, e);
        settle();
        corrupt_en = 1'b0;
        check("t5_done_cycle", 64'(td - t0), 64'd12);
        check("t5_err", 64'(e), 64'd1);
        check("t5_nwrites", 64'(wq_cyc.size()), 64'd4);
        check("t5_err_only_in_done", 64'(count_sig(2, t0, td + 2)), 64'd1);

        // Full table: 512 words at base 0, level 3
        clear_log();
        seed = 40'h12_3456_789A;
        step = 40'h01_0101_0101;
        send_cmd(2'd3, 9'h000, 10'd512, 1'b0, t0);
        send_words(512, 1'b0, seed, step);
        wait_done(2000, td, e);
        settle();
        check("t6_done_cycle", 64'(td - t0), 64'd1028);
        check("t6_err", 64'(e), 64'd0);
        check("t6_nwrites", 64'(wq_cyc.size()), 64'd512);
        if (wq_cyc.size() == 512) begin
            check("t6_last_addr", 64'(wq_addr[511]), 64'h1FF);
            check("t6_last_din",  64'(wq_din[511]),  64'(word_of(seed, step, 511)));
        end
        check("t6_mem_100", 64'(mem[3][9'h100]), 64'(word_of(seed, step, 256)));

        // data_valid toggling every other cycle, count 3
        clear_log();
        send_cmd(2'd0, 9'h100, 10'd3, 1'b0, t0);
        send_words(3, 1'b1, 40'h7, 40'h10);
        wait_done(100, td, e);
        settle();
        check("t7_nwrites", 64'(wq_cyc.size()), 64'd3);
        for (int i = 0; i < 3 && i < wq_cyc.size(); i++) begin
            check($sformatf("t7_wcyc%0d", i), 64'(wq_cyc[i]),  64'(hs[i] + 1));
            check($sformatf("t7_addr%0d", i), 64'(wq_addr[i]), 64'(9'h100 + 9'(i)));
        end
        check("t7_gap", 64'(hs[1] - hs[0]), 64'd2);
        check("t7_dr_last", 64'(s_dr[hs[2]]), 64'd1);
        check("t7_dr_drop", 64'(s_dr[hs[2] + 1]), 64'd0);
        check("t7_done_cycle", 64'(td - hs[2]), 64'd7);
        check("t7_err", 64'(e), 64'd0);

        // cmd_valid held through a load: second command waits for IDLE
        clear_log();
        send_cmd(2'd1, 9'h020, 10'd2, 1'b1, t0);
        bus.cmd_level = 2'd2;
        bus.cmd_base  = 9'h030;
        bus.cmd_count = 10'd1;
        send_words(2, 1'b0, 40'h11, 40'h11);
        wait_done(100, ta, e);
        check("t8a_err", 64'(e), 64'd0);
        send_cmd(2'd2, 9'h030, 10'd1, 1'b0, t1);
        check("t8_second_accept", 64'(t1 - ta), 64'd1);
        check("t8_ready_while_busy", 64'(count_sig(3, t0 + 1, ta)), 64'd0);
        send_words(1, 1'b0, 40'h99, 40'd1);
        wait_done(100, td, e);
        settle();
        check("t8b_done_cycle", 64'(td - t1), 64'd6);
        check("t8b_err", 64'(e), 64'd0);
        check("t8b_mem", 64'(mem[2][9'h030]), 64'h99);

        // Reset mid-WRITE after 2 of 5 words
        clear_log();
        send_cmd(2'd0, 9'h080, 10'd5, 1'b0, t0);
        send_words(2, 1'b0, 40'hA0, 40'd1);
        RST = 1'b1;
        @(negedge clk);
        check("t9_second_write_we",   64'(bus.wr_we),   64'd1);
        check("t9_second_write_addr", 64'(bus.wr_addr), 64'h081);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("t9_after_rst");
        @(posedge clk); #1;
        RST = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t9_no_done", 64'(count_sig(1, t0, cyc - 1)), 64'd0);
        check("t9_mem_kept", 64'(mem[0][9'h081]), 64'hA1);
        send_cmd(2'd0, 9'h090, 10'd1, 1'b0, t0);
        send_words(1, 1'b0, 40'h5A5A, 40'd1);
        wait_done(100, td, e);
        settle();
        check("t9_new_done_cycle", 64'(td - t0), 64'd6);
        check("t9_new_err", 64'(e), 64'd0);
        check("t9_new_mem", 64'(mem[0][9'h090]), 64'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
